// File: rtl/pit_pkg.sv
// Shared constants and types for the pit_dncnt prescaler/divider timer.
// Counter width, reset values and the reload-select encoding live here.
package pit_pkg;

    localparam int CNT_W = 16;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_RST = '0;
    localparam logic RUN_RST = 1'b1;
    localparam logic IRQ_RST = 1'b0;

    // Source of a counter's next value when its bit cells are parallel-loaded.
    typedef enum logic [1:0] {
        LD_HOLD   = 2'd0,
        LD_WRITE  = 2'd1,
        LD_RELOAD = 2'd2
    } ld_sel_e;

    // A host write always wins over a terminal-count reload.
    function automatic ld_sel_e ld_select(input logic we, input logic wrap);
        if (we)
            return LD_WRITE;
        if (wrap)
            return LD_RELOAD;
        return LD_HOLD;
    endfunction

endpackage

// File: rtl/pit_dncnt_if.sv
// Host-side bus of pit_dncnt: reload writes, count enable, counts and irq.
// The oneshot control only exists when PIT_ONESHOT_EN is defined.
interface pit_dncnt_if;
    import pit_pkg::*;

    cnt_t d;
    logic pre_we;
    logic div_we;
    logic en;
`ifdef PIT_ONESHOT_EN
    logic oneshot;
`endif
    cnt_t pre_q;
    cnt_t div_q;
    logic irq;

    modport master (
        output d, pre_we, div_we, en,
`ifdef PIT_ONESHOT_EN
        output oneshot,
`endif
        input  pre_q, div_q, irq
    );

    modport slave (
        input  d, pre_we, div_we, en,
`ifdef PIT_ONESHOT_EN
        input  oneshot,
`endif
        output pre_q, div_q, irq
    );

endinterface

// File: rtl/pit_dncnt_dncnt.sv
// One bit of a ripple-borrow down counter: toggles when a borrow arrives,
// passes a borrow on when it was already 0, parallel-loads on ld.
module dncnt (
    output logic q,
    output logic bo,
    input  logic d,
    input  logic ci,
    input  logic ld,
    input  logic clk,
    input  logic reset
);

    // NOTE: state is assigned with <= so every cell samples its neighbours' pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)
            q <= 1'b0;
        else if (ld)
            q <= d;
        else
            q <= q ^ ci;
    end

    assign bo = ci & ~q;

endmodule

// File: rtl/pit_dncnt.sv
// Programmable interval timer: 16-bit prescaler feeding a 16-bit divider,
// irq pulses on divider expiry. Define PIT_ONESHOT_EN to add the oneshot control.
module pit_dncnt
    import pit_pkg::*;
(
    input logic       sys_clk,
    input logic       reset,
    pit_dncnt_if.slave bus
);

    cnt_t pre_rld, div_rld;
    cnt_t pre_cnt, div_cnt;
    cnt_t pre_nxt, div_nxt;
    logic pre_ld, div_ld;
    ld_sel_e pre_sel, div_sel;
    logic [CNT_W:0] pre_chain, div_chain;
    logic count, pre_wrap, div_wrap;
    logic run, irq_q;

    assign count = bus.en & run & ~(bus.pre_we | bus.div_we);

    // Borrow out of the MSB means "counting while the whole counter is 0".
    assign pre_chain[0] = count;
    assign pre_wrap     = pre_chain[CNT_W];
    assign div_chain[0] = pre_wrap;
    assign div_wrap     = div_chain[CNT_W];

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        pre_sel = ld_select(bus.pre_we, pre_wrap);
        div_sel = ld_select(bus.div_we, div_wrap);
        pre_ld  = (pre_sel != LD_HOLD);
        div_ld  = (div_sel != LD_HOLD);
        pre_nxt = (pre_sel == LD_WRITE) ? bus.d : pre_rld;
        div_nxt = (div_sel == LD_WRITE) ? bus.d : div_rld;
    end

    for (genvar i = 0; i < CNT_W; i++) begin : g_bit
        dncnt u_pre (
            .q     (pre_cnt[i]),
            .bo    (pre_chain[i+1]),
            .d     (pre_nxt[i]),
            .ci    (pre_chain[i]),
            .ld    (pre_ld),
            .clk   (sys_clk),
            .reset (reset)
        );
        dncnt u_div (
            .q     (div_cnt[i]),
            .bo    (div_chain[i+1]),
            .d     (div_nxt[i]),
            .ci    (div_chain[i]),
            .ld    (div_ld),
            .clk   (sys_clk),
            .reset (reset)
        );
    end

    // Reload registers are a handful of flops, so they are reset like the counters.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pre_rld <= CNT_RST;
            div_rld <= CNT_RST;
            irq_q   <= IRQ_RST;
        end else begin
            if (bus.pre_we)
                pre_rld <= bus.d;
            if (bus.div_we)
                div_rld <= bus.d;
            irq_q <= div_wrap;
        end
    end

`ifdef PIT_ONESHOT_EN
    // A divider write re-arms; an expiry in oneshot mode parks the counters at reload.
    always_ff @(posedge sys_clk) begin
        if (reset)
            run <= RUN_RST;
        else if (bus.div_we)
            run <= 1'b1;
        else if (div_wrap && bus.oneshot)
            run <= 1'b0;
    end
`else
    assign run = RUN_RST;
`endif

    assign bus.pre_q = pre_cnt;
    assign bus.div_q = div_cnt;
    assign bus.irq   = irq_q;

endmodule
